// File: rtl/avs_mem_pkg.sv
// Shared constants, debug state encoding and helpers for the Avalon SDRAM responder.
package avs_mem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = 2;

  // Returned for reads whose address lies outside the implemented memory.
  localparam logic [DATA_W-1:0] OOR_DATA = 16'hDEAD;
  localparam logic [15:0]       SAT_MAX  = 16'hFFFF;

  // Debug-only view of the request handshake.
  typedef enum logic [1:0] {
    StIdle,
    StStall,
    StAccept
  } avs_state_e;

  // Increment that sticks at SAT_MAX.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == SAT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/avs_rd_latency_pipe.sv
// Valid+data shift pipe of DEPTH stages with synchronous flush. The last stage
// only loads when a valid word arrives, so its data holds between returns.
module avs_rd_latency_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Shift valids every cycle; move data only alongside a valid.
  always_ff @(posedge clk) begin
    if (flush) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/avalon_sdram_responder.sv
// Avalon-MM responder modelling the SDRAM port: 2**ADDR_W x 16 memory with
// byteenable writes, fixed-latency pipelined reads, programmable waitrequest
// injection and a cap on outstanding reads.
// Optional: define AVS_ACCESS_COUNT_EN to build saturating rd_count/wr_count;
// otherwise both outputs are tied to zero.
module avalon_sdram_responder
  import avs_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned RD_LATENCY  = 2,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] address,
  input  logic [1:0]  byteenable,
  input  logic [15:0] writedata,
  output logic        waitrequest,
  output logic        readdatavalid,
  output logic [15:0] readdata,
  output logic        protocol_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam logic [2:0] PendMax = 3'(MAX_PENDING);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              req;
  logic              is_read;
  logic              in_range;
  logic [ADDR_W-1:0] word_idx;
  logic              wait_active;
  logic              cap_full;
  logic              accept;
  logic              wr_accept;
  logic              rd_accept;
  logic [DATA_W-1:0] rd_word;

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]  pending_q, pending_d;
  logic        protocol_err_q, protocol_err_d;
  avs_state_e  state_q, state_d;

  // Write wins when both strobes are low, so a read is only a read-alone strobe.
  assign req      = chipselect & (~read_n | ~write_n);
  assign is_read  = chipselect & ~read_n & write_n;
  assign in_range = (address[31:ADDR_W] == '0);
  assign word_idx = address[ADDR_W-1:0];
  assign cap_full = is_read & (pending_q == PendMax);

  if (WAIT_CYCLES == 0) begin : g_no_wait
    assign wait_active = 1'b0;
  end else begin : g_wait
    assign wait_active = (wait_cnt_q < 4'(WAIT_CYCLES));
  end

  // Handshake classification: drives waitrequest/accept and the debug state.
  always_comb begin
    state_d     = StIdle;
    waitrequest = 1'b0;
    accept      = 1'b0;
    if (req) begin
      if (wait_active || cap_full) begin
        state_d     = StStall;
        waitrequest = 1'b1;
      end else begin
        state_d = StAccept;
        accept  = 1'b1;
      end
    end
  end

  assign wr_accept = accept & ~write_n;
  assign rd_accept = accept & write_n;
  assign rd_word   = in_range ? mem[word_idx] : OOR_DATA;

  // Next state for the wait counter, outstanding-read count and error flag.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (accept) begin
      wait_cnt_d = '0;
    end else if (req && wait_active) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    pending_d = pending_q;
    if (rd_accept && !readdatavalid) begin
      pending_d = pending_q + 3'd1;
    end else if (!rd_accept && readdatavalid) begin
      pending_d = pending_q - 3'd1;
    end

    protocol_err_d = protocol_err_q;
    if (accept && ((~read_n & ~write_n) || !in_range)) begin
      protocol_err_d = 1'b1;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt_q     <= '0;
      pending_q      <= '0;
      protocol_err_q <= 1'b0;
      state_q        <= StIdle;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      pending_q      <= pending_d;
      protocol_err_q <= protocol_err_d;
      state_q        <= state_d;
    end
  end

  // The registered debug state can only show ACCEPT after an accepted cycle.
  assert property (@(posedge clk) disable iff (!reset_n)
                   (state_q == StAccept) |-> $past(accept));

  // Memory is deliberately not cleared by reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_accept && in_range) begin
      if (byteenable[0]) begin
        mem[word_idx][7:0] <= writedata[7:0];
      end
      if (byteenable[1]) begin
        mem[word_idx][15:8] <= writedata[15:8];
      end
    end
  end

  avs_rd_latency_pipe #(
    .DEPTH (RD_LATENCY),
    .WIDTH (DATA_W)
  ) u_rd_pipe (
    .clk       (clk),
    .flush     (~reset_n),
    .in_valid  (rd_accept),
    .in_data   (rd_word),
    .out_valid (readdatavalid),
    .out_data  (readdata)
  );

  assign protocol_err = protocol_err_q;

`ifdef AVS_ACCESS_COUNT_EN
  logic [15:0] rd_count_q;
  logic [15:0] wr_count_q;

  // Saturating accept counters; error reads and dropped writes still count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (rd_accept) begin
        rd_count_q <= sat_inc(rd_count_q);
      end
      if (wr_accept) begin
        wr_count_q <= sat_inc(wr_count_q);
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_avalon_sdram_responder.sv
// Randomized scoreboard bench for avalon_sdram_responder. The driver keeps a
// word-array memory model and a queue of expected read returns; the monitor
// checks every cycle's outputs against that queue and the expected flags.
module tb_avalon_sdram_responder;

  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned RD_LATENCY  = 4;
  localparam int unsigned WAIT_CYCLES = 1;
  localparam int unsigned MAX_PENDING = 2;
  localparam int unsigned DEPTH       = 2**ADDR_W;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] address = '0;
  logic [1:0]  byteenable = '0;
  logic [15:0] writedata = '0;
  logic        waitrequest;
  logic        readdatavalid;
  logic [15:0] readdata;
  logic        protocol_err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  avalon_sdram_responder #(
    .ADDR_W      (ADDR_W),
    .RD_LATENCY  (RD_LATENCY),
    .WAIT_CYCLES (WAIT_CYCLES),
    .MAX_PENDING (MAX_PENDING)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .chipselect    (chipselect),
    .read_n        (read_n),
    .write_n       (write_n),
    .address       (address),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .waitrequest   (waitrequest),
    .readdatavalid (readdatavalid),
    .readdata      (readdata),
    .protocol_err  (protocol_err),
    .rd_count      (rd_count),
    .wr_count      (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          ret;
  } rd_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  rd_t         sb[$];
  logic [15:0] mem_m [DEPTH];
  int          wcnt = 0;
  bit          perr = 1'b0, perr_nxt = 1'b0;
  int          rdc = 0, rdc_nxt = 0, wrc = 0, wrc_nxt = 0;
  logic [15:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: commit last cycle's flag updates, drive, then apply the model.
  task automatic do_cycle(input logic cs, input logic rn, input logic wn,
                          input logic [31:0] a, input logic [1:0] be,
                          input logic [15:0] wd, input logic rst, output bit acc);
    bit  req, is_wr, inr, exp_wait;
    rd_t e;
    @(posedge clk);
    #1;
    cyc++;
    perr = perr_nxt;
    rdc  = rdc_nxt;
    wrc  = wrc_nxt;
    chipselect = cs;
    read_n     = rn;
    write_n    = wn;
    address    = a;
    byteenable = be;
    writedata  = wd;
    reset_n    = ~rst;
    #2;
    req   = cs && (!rn || !wn);
    is_wr = cs && !wn;
    inr   = (a >> ADDR_W) == 0;
    // Pending reads are those still queued, including one returning this cycle.
    exp_wait = req && ((wcnt < WAIT_CYCLES) ||
                       (!is_wr && sb.size() == int'(MAX_PENDING)));
    chk("waitrequest", {31'b0, waitrequest}, {31'b0, exp_wait});
    acc = req && !exp_wait;
    if (rst) begin
      while (sb.size() > 0 && sb[sb.size()-1].ret > cyc) void'(sb.pop_back());
      wcnt = 0;
      perr_nxt = 1'b0;
      rdc_nxt = 0;
      wrc_nxt = 0;
      acc = 1'b0;
    end else if (acc) begin
      wcnt = 0;
      if (is_wr) begin
        if (inr) begin
          if (be[0]) mem_m[a[ADDR_W-1:0]][7:0]  = wd[7:0];
          if (be[1]) mem_m[a[ADDR_W-1:0]][15:8] = wd[15:8];
        end else begin
          perr_nxt = 1'b1;
        end
        if (!rn) perr_nxt = 1'b1;
        if (wrc_nxt < 65535) wrc_nxt++;
      end else begin
        e.data = inr ? mem_m[a[ADDR_W-1:0]] : 16'hDEAD;
        e.ret  = cyc + int'(RD_LATENCY);
        sb.push_back(e);
        if (!inr) perr_nxt = 1'b1;
        if (rdc_nxt < 65535) rdc_nxt++;
      end
    end else if (req && wcnt < WAIT_CYCLES) begin
      wcnt++;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) do_cycle(1'b0, 1'b1, 1'b1, 32'h0, 2'b00, 16'h0, 1'b0, acc);
  endtask

  task automatic do_reset(input int n);
    bit acc;
    repeat (n) do_cycle(1'b0, 1'b1, 1'b1, 32'h0, 2'b00, 16'h0, 1'b1, acc);
  endtask

  // Present a transfer until accepted, optionally dropping the request while stalled.
  task automatic xfer(input logic rn, input logic wn, input logic [31:0] a,
                      input logic [1:0] be, input logic [15:0] wd, input int drop_pct);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 64) begin
      if (n > 0 && drop_pct > 0 && int'($urandom_range(99)) < drop_pct)
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0, 2'b00, 16'h0, 1'b0, acc);
      else
        do_cycle(1'b1, rn, wn, a, be, wd, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL xfer_timeout: got no accept expected accept within 64 cycles (addr %h)", a);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] be, input logic [15:0] wd);
    xfer(1'b1, 1'b0, a, be, wd, 0);
  endtask

  task automatic rd(input logic [31:0] a);
    xfer(1'b0, 1'b1, a, 2'b11, 16'h0, 0);
  endtask

  // Monitor: compares outputs every cycle, popping the scoreboard on returns.
  initial begin
    bit exp_v;
    forever begin
      @(negedge clk);
      exp_v = sb.size() > 0 && sb[0].ret == cyc;
      chk("readdatavalid", {31'b0, readdatavalid}, {31'b0, exp_v});
      if (exp_v) begin
        chk("readdata", {16'b0, readdata}, {16'b0, sb[0].data});
        last_data = sb[0].data;
        void'(sb.pop_front());
      end else begin
        chk("readdata_hold", {16'b0, readdata}, {16'b0, last_data});
      end
      chk("protocol_err", {31'b0, protocol_err}, {31'b0, perr});
`ifdef AVS_ACCESS_COUNT_EN
      chk("rd_count", {16'b0, rd_count}, rdc);
      chk("wr_count", {16'b0, wr_count}, wrc);
`else
      chk("rd_count", {16'b0, rd_count}, 32'h0);
      chk("wr_count", {16'b0, wr_count}, 32'h0);
`endif
      if (!reset_n) last_data = '0;
    end
  end

  initial begin
    int r;
    logic [31:0] a;
    do_reset(3);
    idle(2);

    // Give every word a known value before anything reads it.
    for (int i = 0; i < int'(DEPTH); i++) wr(32'(i), 2'b11, 16'($urandom));

    wr(32'd3, 2'b11, 16'hBEEF);
    rd(32'd3);
    wr(32'd5, 2'b11, 16'hFFFF);
    wr(32'd5, 2'b01, 16'h1234);
    rd(32'd5);
    idle(6);
    rd(32'h100);
    wr(32'h40, 2'b11, 16'h5555);
    rd(32'd2);
    do_reset(2);
    idle(6);

    for (int i = 0; i < 10; i++) wr(32'(i), 2'b11, 16'(10 * i + 5));
    for (int i = 0; i < 10; i++) rd(32'(i));
    xfer(1'b0, 1'b0, 32'd7, 2'b10, 16'hA5C3, 0);
    rd(32'd7);
    idle(8);
    do_reset(1);

    for (int t = 0; t < 400; t++) begin
      r = int'($urandom_range(15));
      a = ($urandom_range(7) == 0) ? ($urandom | 32'h10) : 32'($urandom_range(DEPTH - 1));
      if (r <= 5) begin
        xfer(1'b1, 1'b0, a, 2'($urandom), 16'($urandom), 20);
      end else if (r <= 12) begin
        xfer(1'b0, 1'b1, a, 2'b11, 16'h0, 20);
        if ($urandom_range(59) == 0) do_reset(2);
      end else if (r == 13) begin
        xfer(1'b0, 1'b0, a, 2'($urandom), 16'($urandom), 20);
      end else begin
        idle(int'($urandom_range(3, 1)));
      end
    end

    for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1);
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d reads outstanding expected 0", sb.size());
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
